// File: rtl/tx_rd_trigger_pkg.sv
// Shared constants for the TX read trigger: buffer sizing, huge-page geometry, FSM codes.
// No logic latency (constants and one combinational helper).
// No flow control of its own.
package tx_rd_trigger_pkg;

  // TX buffer holds 2^(BF+1) QWs; pointers carry one extra wrap bit.
  localparam int BF    = 6;
  localparam int PTR_W = BF + 2;
  localparam int QW_W  = 19;

  localparam logic [PTR_W-1:0] BUF_QW       = PTR_W'(1 << (BF + 1));
  localparam logic [QW_W-1:0]  HUGE_PAGE_QW = 19'h40000;
  localparam logic [QW_W-1:0]  HDR_QW       = 19'h10;
  localparam logic [QW_W-1:0]  MAX_TLP_QW   = 19'd16;

  // FSM encodings; the remaining three codes are unused and recover to IDLE.
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_REQ     = 3'd1;
  localparam logic [2:0] ST_ACK_LOW = 3'd2;
  localparam logic [2:0] ST_CHG     = 3'd3;
  localparam logic [2:0] ST_CHG_LOW = 3'd4;

  // The host tail can never legitimately point past the end of a huge page.
  function automatic logic [QW_W-1:0] clamp_tail(input logic [QW_W-1:0] tail);
    return (tail > HUGE_PAGE_QW) ? HUGE_PAGE_QW : tail;
  endfunction

endpackage

// File: rtl/tx_timeout_cnt.sv
// Partial-request timer: counts while enabled, fires once per 2^TIMEOUT_W enabled cycles.
// timeout_o is combinational on the count; it rises 2^TIMEOUT_W-1 cycles after enable.
// No backpressure; any enable drop clears the count.
module tx_timeout_cnt #(
  parameter int TIMEOUT_W = 16
) (
  input  logic clk156,
  input  logic reset_n,
  input  logic en_i,
  output logic timeout_o
);

  logic [TIMEOUT_W-1:0] cnt_q, cnt_d;

  // Next count: advance (wrapping through all-ones) while enabled, otherwise restart.
  always_comb begin
    cnt_d = en_i ? (cnt_q + TIMEOUT_W'(1)) : '0;
  end

  assign timeout_o = en_i && (cnt_q == '1);

  // Count register.
  always_ff @(posedge clk156 or negedge reset_n) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

endmodule

// File: rtl/tx_rd_trigger.sv
// Issues memory-read requests for host data in the current huge page and signals page change.
// Inputs synced one cycle; a request appears one cycle after the IDLE decision.
// Holds a request until acknowledged; never requests beyond free TX buffer space.
module tx_rd_trigger
  import tx_rd_trigger_pkg::*;
#(
  parameter int TIMEOUT_W = 16
) (
  input  logic             clk156,
  input  logic             reset_n,
  input  logic [PTR_W-1:0] commited_rd_address,
  input  logic [QW_W-1:0]  host_qw_tail,
  input  logic             huge_page_done,
  output logic             rd_req,
  input  logic             rd_req_ack,
  output logic [QW_W-1:0]  rd_req_qw_offset,
  output logic [4:0]       rd_req_qwords,
  output logic             change_huge_page,
  input  logic             change_huge_page_ack
);

  // Single-stage capture of every input before use.
  logic [PTR_W-1:0] rd_q;
  logic [QW_W-1:0]  tail_q;
  logic             done_q, ack_q, chg_ack_q;

  logic [2:0]       state_q, state_d;
  logic [QW_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0] issued_q, issued_d;
  logic             rd_req_q, rd_req_d;
  logic [QW_W-1:0]  offset_q, offset_d;
  logic [4:0]       qwords_q, qwords_d;
  logic             chg_q, chg_d;

  logic [QW_W-1:0]  tail_c, pending, free_ext;
  logic [PTR_W-1:0] used, free;
  logic             pend_small, tmo_en, tmo;

  // Outstanding work and buffer room; pointer math wraps on the extra pointer bit.
  always_comb begin
    tail_c     = clamp_tail(tail_q);
    pending    = (tail_c > head_q) ? (tail_c - head_q) : '0;
    used       = issued_q - rd_q;
    free       = BUF_QW - used;
    free_ext   = QW_W'(free);
    pend_small = (pending != '0) && (pending < MAX_TLP_QW);
    tmo_en     = (state_q == ST_IDLE) && pend_small;
  end

  tx_timeout_cnt #(.TIMEOUT_W(TIMEOUT_W)) u_timeout (
    .clk156    (clk156),
    .reset_n   (reset_n),
    .en_i      (tmo_en),
    .timeout_o (tmo)
  );

  // Request/page-change FSM; each acknowledge is consumed once, then its fall is awaited.
  always_comb begin
    state_d  = state_q;
    head_d   = head_q;
    issued_d = issued_q;
    rd_req_d = rd_req_q;
    offset_d = offset_q;
    qwords_d = qwords_q;
    chg_d    = chg_q;
    case (state_q)
      ST_IDLE: begin
        if ((pending >= MAX_TLP_QW) && (free_ext >= MAX_TLP_QW)) begin
          rd_req_d = 1'b1;
          offset_d = head_q;
          qwords_d = 5'(MAX_TLP_QW);
          state_d  = ST_REQ;
        end else if (pend_small && (free_ext >= pending) && tmo) begin
          rd_req_d = 1'b1;
          offset_d = head_q;
          qwords_d = pending[4:0];
          state_d  = ST_REQ;
        end else if ((pending == '0) && done_q) begin
          chg_d   = 1'b1;
          state_d = ST_CHG;
        end
      end
      ST_REQ: begin
        if (ack_q) begin
          rd_req_d = 1'b0;
          head_d   = head_q + QW_W'(qwords_q);
          issued_d = issued_q + PTR_W'(qwords_q);
          state_d  = ST_ACK_LOW;
        end
      end
      ST_ACK_LOW: begin
        if (!ack_q) state_d = ST_IDLE;
      end
      ST_CHG: begin
        if (chg_ack_q) begin
          chg_d   = 1'b0;
          head_d  = HDR_QW;
          state_d = ST_CHG_LOW;
        end
      end
      ST_CHG_LOW: begin
        if (!chg_ack_q) state_d = ST_IDLE;
      end
      default: begin
        rd_req_d = 1'b0;
        chg_d    = 1'b0;
        state_d  = ST_IDLE;
      end
    endcase
  end

  // State, pointers, registered outputs and input capture.
  always_ff @(posedge clk156 or negedge reset_n) begin
    if (!reset_n) begin
      rd_q      <= '0;
      tail_q    <= '0;
      done_q    <= 1'b0;
      ack_q     <= 1'b0;
      chg_ack_q <= 1'b0;
      state_q   <= ST_IDLE;
      head_q    <= HDR_QW;
      issued_q  <= '0;
      rd_req_q  <= 1'b0;
      offset_q  <= '0;
      qwords_q  <= '0;
      chg_q     <= 1'b0;
    end else begin
      rd_q      <= commited_rd_address;
      tail_q    <= host_qw_tail;
      done_q    <= huge_page_done;
      ack_q     <= rd_req_ack;
      chg_ack_q <= change_huge_page_ack;
      state_q   <= state_d;
      head_q    <= head_d;
      issued_q  <= issued_d;
      rd_req_q  <= rd_req_d;
      offset_q  <= offset_d;
      qwords_q  <= qwords_d;
      chg_q     <= chg_d;
    end
  end

  assign rd_req           = rd_req_q;
  assign rd_req_qw_offset = offset_q;
  assign rd_req_qwords    = qwords_q;
  assign change_huge_page = chg_q;

endmodule

// File: tb/tb_tx_rd_trigger.sv
// Bench for tx_rd_trigger: directed scenarios plus randomized tail/buffer traffic.
// Expected requests come from a page/buffer model kept in plain integers.
// Acknowledges are driven four-phase with random delays and hold times.
module tb_tx_rd_trigger;
  import tx_rd_trigger_pkg::*;

  localparam int TW = 4;

  logic             clk156 = 1'b0;
  logic             reset_n = 1'b0;
  logic [PTR_W-1:0] commited_rd_address = '0;
  logic [18:0]      host_qw_tail = '0;
  logic             huge_page_done = 1'b0;
  logic             rd_req;
  logic             rd_req_ack = 1'b0;
  logic [18:0]      rd_req_qw_offset;
  logic [4:0]       rd_req_qwords;
  logic             change_huge_page;
  logic             change_huge_page_ack = 1'b0;

  int n_cmp = 0;
  int n_err = 0;
  int mutex_bad = 0;

  // Reference model state (unbounded integers; pointers are reduced only at the port).
  int m_head, m_issued, m_rd, m_tail;

  tx_rd_trigger #(.TIMEOUT_W(TW)) dut (
    .clk156               (clk156),
    .reset_n              (reset_n),
    .commited_rd_address  (commited_rd_address),
    .host_qw_tail         (host_qw_tail),
    .huge_page_done       (huge_page_done),
    .rd_req               (rd_req),
    .rd_req_ack           (rd_req_ack),
    .rd_req_qw_offset     (rd_req_qw_offset),
    .rd_req_qwords        (rd_req_qwords),
    .change_huge_page     (change_huge_page),
    .change_huge_page_ack (change_huge_page_ack)
  );

  always #5 clk156 = ~clk156;

  always @(negedge clk156) if (rd_req && change_huge_page) mutex_bad++;

  // Size of the next read the design owes, 0 if none is due.
  function automatic int exp_qw();
    int tail, pend, free;
    tail = (m_tail > 'h40000) ? 'h40000 : m_tail;
    pend = (tail > m_head) ? tail - m_head : 0;
    free = (1 << (BF + 1)) - (m_issued - m_rd);
    if (pend >= 16 && free >= 16) return 16;
    if (pend >= 1 && pend <= 15 && free >= pend) return pend;
    return 0;
  endfunction

  task automatic set_tail(input int t);
    m_tail = t;
    host_qw_tail = 19'(t);
  endtask

  task automatic set_rd(input int v);
    m_rd = v;
    commited_rd_address = PTR_W'(v);
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    rd_req_ack = 1'b0;
    change_huge_page_ack = 1'b0;
    huge_page_done = 1'b0;
    m_head = 16;
    m_issued = 0;
    set_rd(0);
    set_tail(0);
    repeat (2) @(negedge clk156);
    reset_n = 1'b1;
    @(negedge clk156);
  endtask

  // Waits for one request, checks it against the model, acks it four-phase.
  task automatic do_req(input int ack_hold);
    int e_qw, e_off, hits;
    bit got, stable;
    e_qw = exp_qw();
    e_off = m_head;
    got = 0;
    for (int n = 0; n < 200 && !got; n++) begin
      @(negedge clk156);
      got = rd_req;
    end
    n_cmp++;
    if (!got) begin
      n_err++;
      $display("FAIL req_seen: rd_req stayed 0 for 200 cycles, want request at offset %0h", e_off);
      return;
    end
    n_cmp++;
    if (rd_req_qw_offset !== 19'(e_off)) begin
      n_err++;
      $display("FAIL req_offset: got %0h want %0h", rd_req_qw_offset, e_off);
    end
    n_cmp++;
    if (rd_req_qwords !== 5'(e_qw)) begin
      n_err++;
      $display("FAIL req_qwords: got %0d want %0d (offset %0h)", rd_req_qwords, e_qw, e_off);
    end
    stable = 1;
    repeat ($urandom_range(0, 3)) begin
      @(negedge clk156);
      if (rd_req !== 1'b1 || rd_req_qw_offset !== 19'(e_off) || rd_req_qwords !== 5'(e_qw))
        stable = 0;
    end
    rd_req_ack = 1'b1;
    got = 0;
    for (int n = 0; n < 20 && !got; n++) begin
      @(negedge clk156);
      got = !rd_req;
    end
    n_cmp++;
    if (!got || !stable) begin
      n_err++;
      $display("FAIL req_hold: stable=%0d dropped_after_ack=%0d, want 1 and 1", stable, got);
    end
    hits = 0;
    repeat (ack_hold) begin
      @(negedge clk156);
      if (rd_req) hits++;
    end
    rd_req_ack = 1'b0;
    m_head += e_qw;
    m_issued += e_qw;
    if (ack_hold > 0) begin
      n_cmp++;
      if (hits != 0) begin
        n_err++;
        $display("FAIL ack_level: rd_req high %0d cycles while ack held, want 0", hits);
      end
    end
  endtask

  task automatic expect_idle(input int cycles, input string name);
    int hits;
    hits = 0;
    repeat (cycles) begin
      @(negedge clk156);
      if (rd_req) hits++;
    end
    n_cmp++;
    if (hits != 0) begin
      n_err++;
      $display("FAIL %s: rd_req high %0d cycles, want 0", name, hits);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    @(negedge clk156);
    n_cmp++; if (rd_req !== 1'b0) begin n_err++; $display("FAIL rst_rd_req: got %b want 0", rd_req); end
    n_cmp++; if (change_huge_page !== 1'b0) begin n_err++; $display("FAIL rst_chg: got %b want 0", change_huge_page); end
    n_cmp++; if (rd_req_qwords !== 5'd0) begin n_err++; $display("FAIL rst_qwords: got %0d want 0", rd_req_qwords); end
    n_cmp++; if (rd_req_qw_offset !== 19'd0) begin n_err++; $display("FAIL rst_offset: got %0h want 0", rd_req_qw_offset); end
    n_cmp++; if (dut.head_q !== 19'h10) begin n_err++; $display("FAIL rst_head: got %0h want 10", dut.head_q); end
    n_cmp++; if (dut.issued_q !== '0) begin n_err++; $display("FAIL rst_issued: got %0h want 0", dut.issued_q); end
    apply_reset();
  endtask

  task automatic test_two_full();
    apply_reset();
    set_tail('h30);
    do_req(0);
    do_req(0);
    expect_idle(30, "two_full_idle");
    n_cmp++;
    if (dut.head_q !== 19'(m_head)) begin
      n_err++;
      $display("FAIL two_full_head: got %0h want %0h", dut.head_q, m_head);
    end
  endtask

  task automatic test_timeout();
    apply_reset();
    set_tail('h15);
    expect_idle(16, "timeout_early");
    @(negedge clk156);
    n_cmp++;
    if (rd_req !== 1'b1) begin
      n_err++;
      $display("FAIL timeout_fire: rd_req=%b on 17th cycle, want 1", rd_req);
    end
    do_req(0);
    expect_idle(40, "timeout_after");
  endtask

  task automatic test_buffer_full();
    apply_reset();
    set_tail('h90);
    for (int i = 0; i < 8; i++) do_req($urandom_range(0, 2));
    set_tail('h100);
    expect_idle(40, "full_no_req");
    set_rd(15);
    expect_idle(30, "free15_no_req");
    set_rd(16);
    do_req(0);
    expect_idle(30, "full_again");
  endtask

  task automatic test_ack_held();
    apply_reset();
    set_tail('h30);
    do_req(10);
    n_cmp++;
    if (dut.head_q !== 19'(m_head)) begin
      n_err++;
      $display("FAIL ack_once_head: got %0h want %0h", dut.head_q, m_head);
    end
    do_req(0);
    expect_idle(30, "ack_held_idle");
  endtask

  task automatic test_change();
    bit got;
    apply_reset();
    force dut.head_q = 19'h3FFF0;
    @(negedge clk156);
    release dut.head_q;
    m_head = 'h3FFF0;
    set_tail('h7FFFF);
    huge_page_done = 1'b1;
    do_req(0);
    got = 0;
    for (int n = 0; n < 100 && !got; n++) begin
      @(negedge clk156);
      got = change_huge_page;
    end
    n_cmp++;
    if (!got) begin n_err++; $display("FAIL chg_seen: change_huge_page=0 after 100 cycles, want 1"); end
    n_cmp++;
    if (rd_req !== 1'b0) begin n_err++; $display("FAIL chg_excl: rd_req=%b during change, want 0", rd_req); end
    set_tail('h20);
    huge_page_done = 1'b0;
    change_huge_page_ack = 1'b1;
    got = 0;
    for (int n = 0; n < 20 && !got; n++) begin
      @(negedge clk156);
      got = !change_huge_page;
    end
    m_head = 16;
    n_cmp++;
    if (!got) begin n_err++; $display("FAIL chg_drop: change_huge_page stayed 1 after ack, want 0"); end
    n_cmp++;
    if (dut.head_q !== 19'(m_head)) begin n_err++; $display("FAIL chg_head: got %0h want %0h", dut.head_q, m_head); end
    change_huge_page_ack = 1'b0;
    do_req(0);
    expect_idle(30, "chg_idle");
  endtask

  task automatic test_reset_mid();
    bit got;
    apply_reset();
    set_tail('h30);
    got = 0;
    for (int n = 0; n < 50 && !got; n++) begin
      @(negedge clk156);
      got = rd_req;
    end
    n_cmp++;
    if (!got) begin n_err++; $display("FAIL midrst_req: rd_req=0 after 50 cycles, want 1"); end
    rd_req_ack = 1'b1;
    @(posedge clk156);
    #2 reset_n = 1'b0;
    #1;
    n_cmp++; if (rd_req !== 1'b0) begin n_err++; $display("FAIL midrst_rd_req: got %b want 0", rd_req); end
    n_cmp++; if (dut.head_q !== 19'h10) begin n_err++; $display("FAIL midrst_head: got %0h want 10", dut.head_q); end
    n_cmp++; if (dut.issued_q !== '0) begin n_err++; $display("FAIL midrst_issued: got %0h want 0", dut.issued_q); end
    rd_req_ack = 1'b0;
    m_head = 16;
    m_issued = 0;
    @(negedge clk156);
    reset_n = 1'b1;
    do_req(0);
  endtask

  task automatic test_random();
    int inc, back, nrd;
    apply_reset();
    for (int it = 0; it < 25; it++) begin
      inc = $urandom_range(1, 40);
      back = $urandom_range(0, 64);
      nrd = m_issued - back;
      if (nrd < m_rd) nrd = m_rd;
      set_rd(nrd);
      set_tail(m_tail + inc);
      while (exp_qw() != 0) do_req($urandom_range(0, 4));
      expect_idle(24, "rand_idle");
    end
  endtask

  initial begin
    test_reset();
    test_two_full();
    test_timeout();
    test_buffer_full();
    test_ack_held();
    test_change();
    test_reset_mid();
    test_random();
    n_cmp++;
    if (mutex_bad != 0) begin
      n_err++;
      $display("FAIL mutex: rd_req and change_huge_page both high %0d cycles, want 0", mutex_bad);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/tx_rd_trigger.md
TX_RD_TRIGGER -- requirements
Module: tx_rd_trigger

Interface
REQ-001 SHALL have parameter TIMEOUT_W, default 16, width of the partial-request timeout counter.
REQ-002 SHALL have port clk156  in  1  156.25 MHz clock, the only clock.
REQ-003 SHALL have port reset_n  in  1  asynchronous, active-low reset.
REQ-004 SHALL have port commited_rd_address  in  `BF+2  TX buffer read pointer from the MAC side, driven from the 156.25 MHz domain.
REQ-005 SHALL have port host_qw_tail  in  19  QW offset one past the last QW the host wrote into the current huge page, driven from the 250 MHz domain.
REQ-006 SHALL have port huge_page_done  in  1  host has finished the current huge page, driven from the 250 MHz domain.
REQ-007 SHALL have port rd_req  out  1  request one memory-read TLP.
REQ-008 SHALL have port rd_req_ack  in  1  four-phase acknowledge of rd_req, driven from the 250 MHz domain.
REQ-009 SHALL have port rd_req_qw_offset  out  19  QW offset of the read within the huge page.
REQ-010 SHALL have port rd_req_qwords  out  5  read length in QWs (1..16).
REQ-011 SHALL have port change_huge_page  out  1  current huge page fully consumed.
REQ-012 SHALL have port change_huge_page_ack  in  1  four-phase acknowledge, driven from the 250 MHz domain.

Function
REQ-013 SHALL register commited_rd_address, host_qw_tail, huge_page_done, rd_req_ack and change_huge_page_ack once in clk156 before any use.
REQ-014 SHALL keep head (19 b, QW offset of the next read) and issued (`BF+2 b, TX buffer write pointer including in-flight reads).
- free = 2^(`BF+1) − (issued − rd_reg), computed modulo 2^(`BF+2).
- pending = tail_reg − head when tail_reg > head, else 0.
- tail_reg values above 0x40000 SHALL be clamped to 0x40000.
REQ-015 SHALL implement FSM states IDLE, REQ, ACK_LOW, CHG, CHG_LOW.
REQ-016 In IDLE, SHALL evaluate in priority order:
- (a) pending ≥ 16 and free ≥ 16: rd_req_qwords = 16, go to REQ.
- (b) 1 ≤ pending ≤ 15 and free ≥ pending and timeout: rd_req_qwords = pending, go to REQ.
- (c) pending = 0 and done_reg: go to CHG.
- (d) otherwise stay in IDLE.
REQ-017 On the IDLE→REQ transition, SHALL drive rd_req = 1 and rd_req_qw_offset = head on the next cycle and hold both, together with rd_req_qwords, stable until ack.
REQ-018 In REQ, when ack_reg = 1, SHALL:
- drop rd_req;
- add rd_req_qwords to head and to issued (issued wraps modulo 2^(`BF+2));
- go to ACK_LOW.
REQ-019 In ACK_LOW, SHALL return to IDLE only after ack_reg = 0; a level-high ack SHALL never be counted twice.
REQ-020 In CHG, SHALL assert change_huge_page; on chg_ack_reg = 1, SHALL deassert it, set head = 0x10 and go to CHG_LOW.
REQ-021 In CHG_LOW, SHALL return to IDLE once chg_ack_reg = 0.
REQ-022 The timeout counter SHALL:
- increment in IDLE while 1 ≤ pending ≤ 15;
- clear in all other cases;
- pulse timeout for one cycle when it reaches all ones, then wrap.
REQ-023 SHALL never issue a read whose head + qwords exceeds 0x40000.
REQ-024 SHALL never let issued − rd_reg exceed 2^(`BF+1) (buffer full: no request).
REQ-025 SHALL hold rd_req and change_huge_page mutually exclusive.

Reset
REQ-026 On reset_n low, SHALL immediately clear rd_req, change_huge_page, rd_req_qwords, rd_req_qw_offset, issued, the timeout counter and all sync registers.
REQ-027 On reset_n low, SHALL set head = 0x10 and FSM = IDLE.
REQ-028 Reset asserted mid-handshake SHALL abandon the transaction, with no head or issued update.
REQ-029 Unused FSM encodings SHALL return to IDLE.

Structure
REQ-030 `BF, the huge-page size 0x40000, the header offset 0x10 and the maximum TLP size of 16 QW SHALL live in the shared includes package.
REQ-031 The timeout counter SHALL be a sub-module, tx_timeout_cnt, parameterised by TIMEOUT_W.

Verification
REQ-032 Bench SHALL cover: tail 0x30, free buffer → two requests (offset 0x10, qwords 16; offset 0x20, qwords 16), head ends at 0x30.
REQ-033 Bench SHALL cover: tail 0x15, TIMEOUT_W = 4 → no request for 16 cycles, then one request (offset 0x10, qwords 5).
REQ-034 Bench SHALL cover: buffer full (issued − rd = 2^(`BF+1)), tail 0x100 → no rd_req; rd advanced by 16 → one 16-QW request.
REQ-035 Bench SHALL cover: ack held high for 10 cycles → exactly one head increment; next rd_req only after ack falls.
REQ-036 Bench SHALL cover: head = tail = 0x40000, done = 1 → change_huge_page; ack → head = 0x10; tail 0x20 → next request at offset 0x10.
REQ-037 Bench SHALL cover: reset_n pulsed low while rd_req is high → rd_req = 0 asynchronously, head = 0x10, issued = 0.
